rsp_reorder_buf: RTL and testbench
==================================

// Module: rsp_reorder_buf
// PURPOSE
//  Downstream of execution_unit. Accepts its out-of-order responses (mul/add latencies differ)
//  and re-emits them strictly in ascending req_id order, wrapping 7->0.
//  ID-indexed slot array with a head pointer and a registered, back-pressurable output stage.
//  Upstream issues req_ids sequentially from 0 and never reuses an id before it is delivered here.
// PARAMETERS
//  ID_W    3   response id width; slot count = 2**ID_W
//  DATA_W  64  response data width
// PORTS
//  clk        in   1          clock; all state on posedge
//  rst        in   1          asynchronous, active-high reset
//  rsp_valid  in   1          response strobe (execution_unit output_rsp.rsp); no ready, always accepted
//  rsp_id     in   ID_W       response id (output_rsp.rsp_id)
//  rsp_data   in   DATA_W     response data (output_rsp.rsp_data)
//  out_valid  out  1          in-order response valid (registered)
//  out_id     out  ID_W       id of delivered response (registered)
//  out_data   out  DATA_W     data of delivered response (registered)
//  out_ready  in   1          downstream accepts when out_valid && out_ready
//  occupancy  out  ID_W+1     count of filled slots, excluding output register
//  dup_err    out  1          1-cycle pulse: response hit an already-filled slot
// BEHAVIOUR
//  Reset (async, rst=1): all slot valid bits=0, head=0, out_valid=0, out_id=0, out_data=0,
//   occupancy=0, dup_err=0. Reset mid-stream discards all slots and the output register; head restarts at 0.
//  Slot write: rsp_valid && !slot_v[rsp_id] -> slot[rsp_id]<=rsp_data, slot_v set at the clock edge.
//  Duplicate: rsp_valid && slot_v[rsp_id] -> slot contents kept, new data dropped, dup_err=1 next cycle.
//  Output load: load_ok = !out_valid || out_ready. If load_ok && slot_v[head]: out_data<=slot[head],
//   out_id<=head, out_valid<=1, slot_v[head] cleared, head<=head+1 (mod 2**ID_W, 7->0 wraps).
//   If load_ok && !slot_v[head]: out_valid<=0.
//  Hold: out_valid && !out_ready -> out_* stable; head and slots unchanged; slots keep filling.
//  Throughput: one delivery per cycle when the head slot is continuously filled and out_ready=1.
//  Latency (macro off): response at head id in cycle N -> out_valid in cycle N+2.
//  Simultaneous write to slot X and drain of slot X in the same cycle: cannot occur legally
//   (slot_v[X]=1 means the write is a duplicate). The drain wins; the write is flagged dup_err.
//  occupancy: +1 on slot write, -1 on drain, net 0 when both happen. Max value 2**ID_W.
//  Full: all slots filled is legal. Overflow is impossible under the id-reuse rule; otherwise dup_err.
// CONFIGURATION
//  RSP_REORDER_BYPASS_EN defined: when rsp_valid && rsp_id==head && !slot_v[head] && load_ok,
//   the response loads directly into the output register (slot not written, occupancy unchanged,
//   head++). Latency becomes N+1.
//  RSP_REORDER_BYPASS_EN undefined: no bypass path; every response passes through a slot (N+2).
//  Ordering, dup_err and backpressure rules are identical in both builds.
// TESTING
//  1 In-order: ids 0,1,2 data 0x10,0x11,0x12 on consecutive cycles, out_ready=1 -> out ids 0,1,2
//    back-to-back with matching data. First out_valid at N+2 (N+1 with BYPASS_EN).
//  2 Reverse: ids 3,2,1,0 data 0xA3..0xA0 -> nothing out until id0 arrives, then 0,1,2,3 on 4
//    consecutive cycles; occupancy peaks at 4 (3 with BYPASS_EN).
//  3 Backpressure: 8 responses ids 0-7, out_ready=0 -> out_valid=1, id0 held stable;
//    occupancy=7; release out_ready -> ids 0..7 in order, no loss.
//  4 Wrap: stream ids 0..7 then 0..2 (data=0x100+seq) -> 11 outputs in order;
//    head wraps 7->0; dup_err never asserts.
//  5 Duplicate: id5 (0x55) then id5 (0x99) while head=0 -> dup_err pulse one cycle;
//    id5 later delivered with 0x55.
//  6 Reset mid-op: slots 1,2 filled, out_valid=1 with id0; assert rst -> all outputs 0 immediately;
//    after release, id0 with 0x7 -> out id0 data 0x7.

Source files
------------

// File: rtl/rsp_reorder_buf.sv
// ---------------------------------------------------------------------------
// rsp_reorder_buf
//
// Purpose:
//   Re-orders the out-of-order responses of the execution unit (multiply and
//   add paths have different latencies) back into ascending request-id
//   order, wrapping from 2**ID_W-1 to 0. Each response is parked in the slot
//   indexed by its id. A head pointer walks the slots in order and moves the
//   head response into a registered output stage that honours downstream
//   back-pressure.
//
//   The upstream issues ids sequentially from 0 and never reuses an id before
//   it has been delivered here. A response that lands on an already-filled
//   slot is therefore an error: it is dropped and flagged on dup_err.
//
// Optional feature (compile-time macro):
//   RSP_REORDER_BYPASS_EN
//     defined   : a response whose id equals the head, arriving while the
//                 head slot is empty and the output stage can load, goes
//                 straight into the output register (latency N+1).
//     undefined : every response is parked in a slot first (latency N+2).
//
// Parameters:
//   ID_W      response id width; slot count = 2**ID_W
//   DATA_W    response data width
//
// Ports:
//   clk        in   1         clock, all state on rising edge
//   rst        in   1         asynchronous active-high reset
//   rsp_valid  in   1         response strobe, always accepted
//   rsp_id     in   ID_W      response id
//   rsp_data   in   DATA_W    response data
//   out_valid  out  1         in-order response valid (registered)
//   out_id     out  ID_W      id of the delivered response (registered)
//   out_data   out  DATA_W    data of the delivered response (registered)
//   out_ready  in   1         downstream accepts when out_valid && out_ready
//   occupancy  out  ID_W+1    filled slots, output register not counted
//   dup_err    out  1         one-cycle pulse: response hit a filled slot
// ---------------------------------------------------------------------------
module rsp_reorder_buf #(
   parameter int ID_W   = 3,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rsp_valid,
   input  logic [ID_W-1:0]   rsp_id,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              out_valid,
   output logic [ID_W-1:0]   out_id,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [ID_W:0]     occupancy,
   output logic              dup_err
);

   localparam int SLOTS = 2 ** ID_W;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [SLOTS-1:0]  r_slot_v;
   logic [DATA_W-1:0] r_slot_data [SLOTS];
   logic [ID_W-1:0]   r_head;
   logic              r_out_valid;
   logic [ID_W-1:0]   r_out_id;
   logic [DATA_W-1:0] r_out_data;
   logic [ID_W:0]     r_occupancy;
   logic              r_dup_err;

   // ------------------------------------------------------------------------
   // Per-cycle decisions
   // ------------------------------------------------------------------------
   logic              w_load_ok;   // output register is free or being emptied
   logic              w_head_v;    // head slot holds the next in-order response
   logic              w_drain;     // head slot moves into the output register
   logic              w_dup;       // incoming response collides with a filled slot
   logic              w_bypass;    // incoming response goes straight to output
   logic              w_write;     // incoming response is parked in its slot
   logic [ID_W:0]     w_occ_next;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_load_ok  = !r_out_valid || out_ready;
      w_head_v   = r_slot_v[r_head];
      w_drain    = w_load_ok && w_head_v;
      w_dup      = rsp_valid && r_slot_v[rsp_id];
`ifdef RSP_REORDER_BYPASS_EN
      // Only legal when the head slot is empty, so it can never compete
      // with a drain for the output register.
      w_bypass   = rsp_valid && (rsp_id == r_head) && !w_head_v && w_load_ok;
`else
      w_bypass   = 1'b0;
`endif
      w_write    = rsp_valid && !r_slot_v[rsp_id] && !w_bypass;

      // Write and drain in the same cycle cancel out.
      w_occ_next = r_occupancy;
      case ({w_write, w_drain})
         2'b10:   w_occ_next = r_occupancy + (ID_W+1)'(1);
         2'b01:   w_occ_next = r_occupancy - (ID_W+1)'(1);
         default: w_occ_next = r_occupancy;
      endcase
   end

   // ------------------------------------------------------------------------
   // Slot valid bits
   // ------------------------------------------------------------------------
   // A write never targets the slot being drained (that slot is full, so the
   // write would be a duplicate); the clear is placed last so a drain would
   // win regardless.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register sees the pre-edge values of the others.
      if (rst) begin
         r_slot_v <= '0;
      end else begin
         if (w_write) r_slot_v[rsp_id] <= 1'b1;
         if (w_drain) r_slot_v[r_head] <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Slot data storage
   // ------------------------------------------------------------------------
   // NOTE: the data array is deliberately not reset; contents are only ever
   // read behind a set valid bit, so resetting it would buy nothing.
   always_ff @(posedge clk) begin
      if (w_write) r_slot_data[rsp_id] <= rsp_data;
   end

   // ------------------------------------------------------------------------
   // Head pointer and output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head      <= '0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_out_data  <= '0;
      end else if (w_load_ok) begin
         if (w_head_v) begin
            r_out_valid <= 1'b1;
            r_out_id    <= r_head;
            r_out_data  <= r_slot_data[r_head];
            r_head      <= r_head + ID_W'(1);
         end else if (w_bypass) begin
            r_out_valid <= 1'b1;
            r_out_id    <= rsp_id;
            r_out_data  <= rsp_data;
            r_head      <= r_head + ID_W'(1);
         end else begin
            // Nothing in order is ready; id/data keep their last values.
            r_out_valid <= 1'b0;
         end
      end
      // When !w_load_ok the output is stalled: everything above holds.
   end

   // ------------------------------------------------------------------------
   // Occupancy and duplicate flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occupancy <= '0;
         r_dup_err   <= 1'b0;
      end else begin
         r_occupancy <= w_occ_next;
         r_dup_err   <= w_dup;
      end
   end

   assign out_valid = r_out_valid;
   assign out_id    = r_out_id;
   assign out_data  = r_out_data;
   assign occupancy = r_occupancy;
   assign dup_err   = r_dup_err;

endmodule

// File: tb/tb_rsp_reorder_buf.sv
// ---------------------------------------------------------------------------
// tb_rsp_reorder_buf
//
// Directed bench for rsp_reorder_buf. A reference model holds the pending
// responses in an associative array keyed by id, tracks the next sequence
// number to deliver and the contents of the output stage. A compare process
// checks every DUT output against that model on each falling edge. Each
// scenario also checks the model's delivery log and a few DUT values against
// hand-computed literals.
// ---------------------------------------------------------------------------
module tb_rsp_reorder_buf;

   localparam int ID_W   = 3;
   localparam int DATA_W = 64;
   localparam int SLOTS  = 2 ** ID_W;
`ifdef RSP_REORDER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              rsp_valid;
   logic [ID_W-1:0]   rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              out_valid;
   logic [ID_W-1:0]   out_id;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [ID_W:0]     occupancy;
   logic              dup_err;

   rsp_reorder_buf #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy),
      .dup_err   (dup_err)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Check bookkeeping
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   logic [63:0] pend [int];      // responses waiting, keyed by id
   int          m_seq;           // sequence number of the next delivery
   bit          m_out_v;
   int          m_out_id;
   logic [63:0] m_out_d;
   bit          m_dup;
   int          log_id[$];       // responses the downstream accepted
   logic [63:0] log_d[$];

   task automatic model_step();
      int          head;
      bit          can_load;
      bit          byp;
      bit          dup;
      int          id;
      if (rst) begin
         pend.delete();
         m_seq    = 0;
         m_out_v  = 1'b0;
         m_out_id = 0;
         m_out_d  = '0;
         m_dup    = 1'b0;
      end else begin
         id       = int'(rsp_id);
         head     = m_seq % SLOTS;
         can_load = !m_out_v || out_ready;
         if (m_out_v && out_ready) begin
            log_id.push_back(m_out_id);
            log_d.push_back(m_out_d);
         end
         dup = rsp_valid && pend.exists(id);
         byp = BYP && rsp_valid && id == head && !pend.exists(head) && can_load;
         if (can_load) begin
            if (pend.exists(head)) begin
               m_out_v  = 1'b1;
               m_out_id = head;
               m_out_d  = pend[head];
               pend.delete(head);
               m_seq++;
            end else if (byp) begin
               m_out_v  = 1'b1;
               m_out_id = id;
               m_out_d  = rsp_data;
               m_seq++;
            end else begin
               m_out_v  = 1'b0;
            end
         end
         if (rsp_valid && !dup && !byp) pend[id] = rsp_data;
         m_dup = dup;
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   // ------------------------------------------------------------------------
   // Cycle-by-cycle compare against the model
   // ------------------------------------------------------------------------
   bit saw_dup;

   always @(negedge clk) begin
      if (!rst) begin
         check("out_valid", 64'(out_valid), 64'(m_out_v));
         if (m_out_v) begin
            check("out_id", 64'(out_id), 64'(m_out_id));
            check("out_data", out_data, m_out_d);
         end
         check("occupancy", 64'(occupancy), 64'(pend.num()));
         check("dup_err", 64'(dup_err), 64'(m_dup));
         if (dup_err) saw_dup = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   int          exp_id[$];
   logic [63:0] exp_d[$];

   task automatic cyc(input bit v, input int id, input logic [63:0] d, input bit rdy);
      @(negedge clk);
      rsp_valid = v;
      rsp_id    = ID_W'(id);
      rsp_data  = d;
      out_ready = rdy;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      rsp_data  = '0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      log_id.delete();
      log_d.delete();
      exp_id.delete();
      exp_d.delete();
      saw_dup = 1'b0;
   endtask

   task automatic expect_out(input int id, input logic [63:0] d);
      exp_id.push_back(id);
      exp_d.push_back(d);
   endtask

   task automatic compare_log(input string name);
      int n;
      check($sformatf("%s_count", name), 64'(log_id.size()), 64'(exp_id.size()));
      n = (log_id.size() < exp_id.size()) ? log_id.size() : exp_id.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_id[%0d]", name, i), 64'(log_id[i]), 64'(exp_id[i]));
         check($sformatf("%s_data[%0d]", name, i), log_d[i], exp_d[i]);
      end
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      rsp_data  = '0;
      out_ready = 1'b0;
      #12;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_id", 64'(out_id), 64'd0);
      check("reset_out_data", out_data, 64'd0);
      check("reset_occupancy", 64'(occupancy), 64'd0);
      check("reset_dup_err", 64'(dup_err), 64'd0);

      // 1: in-order stream, latency of the first delivery
      do_reset();
      cyc(1'b1, 0, 64'h10, 1'b1);
      @(posedge clk); #1;
      check("t1_first_valid", 64'(out_valid), 64'(BYP));
      cyc(1'b1, 1, 64'h11, 1'b1);
      @(posedge clk); #1;
      check("t1_second_valid", 64'(out_valid), 64'd1);
      check("t1_second_id", 64'(out_id), 64'(BYP));
      cyc(1'b1, 2, 64'h12, 1'b1);
      idle(5, 1'b1);
      expect_out(0, 64'h10); expect_out(1, 64'h11); expect_out(2, 64'h12);
      compare_log("t1");

      // 2: reverse arrival; nothing leaves until id0 shows up
      do_reset();
      cyc(1'b1, 3, 64'hA3, 1'b1);
      cyc(1'b1, 2, 64'hA2, 1'b1);
      cyc(1'b1, 1, 64'hA1, 1'b1);
      @(posedge clk); #1;
      check("t2_no_early_out", 64'(out_valid), 64'd0);
      cyc(1'b1, 0, 64'hA0, 1'b1);
      @(posedge clk); #1;
      check("t2_peak_occupancy", 64'(occupancy), BYP ? 64'd3 : 64'd4);
      idle(7, 1'b1);
      for (int i = 0; i < 4; i++) expect_out(i, 64'hA0 + 64'(i));
      compare_log("t2");

      // 3: back-pressure with all eight ids outstanding
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, i, 64'h30 + 64'(i), 1'b0);
      idle(3, 1'b0);
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_id", 64'(out_id), 64'd0);
      check("t3_hold_data", out_data, 64'h30);
      check("t3_hold_occupancy", 64'(occupancy), 64'd7);
      idle(12, 1'b1);
      for (int i = 0; i < 8; i++) expect_out(i, 64'h30 + 64'(i));
      compare_log("t3");

      // 4: eleven responses, head wraps 7 -> 0
      do_reset();
      for (int s = 0; s < 11; s++) cyc(1'b1, s % SLOTS, 64'h100 + 64'(s), 1'b1);
      idle(6, 1'b1);
      for (int s = 0; s < 11; s++) expect_out(s % SLOTS, 64'h100 + 64'(s));
      compare_log("t4");
      check("t4_no_dup", 64'(saw_dup), 64'd0);

      // 5: duplicate id5 is dropped and flagged for exactly one cycle
      do_reset();
      cyc(1'b1, 5, 64'h55, 1'b1);
      cyc(1'b1, 5, 64'h99, 1'b1);
      @(posedge clk); #1;
      check("t5_dup_pulse", 64'(dup_err), 64'd1);
      cyc(1'b0, 0, '0, 1'b1);
      @(posedge clk); #1;
      check("t5_dup_clear", 64'(dup_err), 64'd0);
      for (int i = 0; i < 5; i++) cyc(1'b1, i, 64'h50 + 64'(i), 1'b1);
      idle(8, 1'b1);
      for (int i = 0; i < 6; i++) expect_out(i, 64'h50 + 64'(i));
      compare_log("t5");

      // 6: reset while output is stalled and slots are occupied
      do_reset();
      cyc(1'b1, 0, 64'h70, 1'b0);
      cyc(1'b1, 1, 64'h71, 1'b0);
      cyc(1'b1, 2, 64'h72, 1'b0);
      idle(2, 1'b0);
      check("t6_pre_valid", 64'(out_valid), 64'd1);
      check("t6_pre_id", 64'(out_id), 64'd0);
      check("t6_pre_occupancy", 64'(occupancy), 64'd2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_id", 64'(out_id), 64'd0);
      check("t6_rst_data", out_data, 64'd0);
      check("t6_rst_occupancy", 64'(occupancy), 64'd0);
      check("t6_rst_dup", 64'(dup_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      log_id.delete();
      log_d.delete();
      exp_id.delete();
      exp_d.delete();
      cyc(1'b1, 0, 64'h7, 1'b1);
      idle(4, 1'b1);
      expect_out(0, 64'h7);
      compare_log("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
